// File: rtl/sequence_detector_moore_verilog.sv
// Serial pattern detector, Moore FSM. State Sk = length of the longest suffix
// of the input history that is also a prefix of the pattern. The transition
// table is derived from PATTERN/PATTERN_LEN at elaboration (KMP failure rule).
module sequence_detector_moore_verilog #(
   parameter logic [15:0] PATTERN     = 16'b0000_0000_0000_1011,
   parameter int          PATTERN_LEN = 4,
   parameter bit          OVERLAP     = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic sequence_in,
   output logic detector_out
);

   localparam int SW = $clog2(PATTERN_LEN + 1);

   // Only idle and match have fixed meaning; intermediate states are k casts.
   typedef enum logic [SW-1:0] {
      S_IDLE  = '0,
      S_MATCH = SW'(PATTERN_LEN)
   } state_e;

   // Next state after having matched k pattern bits and then receiving b:
   // longest pattern prefix that is a suffix of (prefix_k, b), capped at N.
   // Pattern bit i in time order is PATTERN[PATTERN_LEN-1-i].
   function automatic int next_fn(input int k, input logic b);
      logic [16:0] str;
      int          len;
      int          res;
      logic        ok;
      str = '0;
      len = k + 1;
      for (int i = 0; i < 16; i++) begin
         if (i < k) str[i] = PATTERN[PATTERN_LEN-1-i];
      end
      str[k] = b;
      res    = 0;
      for (int j = 1; j <= 16; j++) begin
         if (j <= len && j <= PATTERN_LEN) begin
            ok = 1'b1;
            for (int i = 0; i < 16; i++) begin
               if (i < j && str[len-j+i] != PATTERN[PATTERN_LEN-1-i]) ok = 1'b0;
            end
            if (ok) res = j;
         end
      end
      return res;
   endfunction

   logic [SW-1:0] nxt0_tbl [PATTERN_LEN+1];
   logic [SW-1:0] nxt1_tbl [PATTERN_LEN+1];

   // Elaboration-time transition table; without overlap the match state
   // forgets its history and behaves exactly like idle.
   for (genvar k = 0; k <= PATTERN_LEN; k++) begin : g_tbl
      localparam int KK = (k == PATTERN_LEN && !OVERLAP) ? 0 : k;
      localparam logic [SW-1:0] N0 = SW'(next_fn(KK, 1'b0));
      localparam logic [SW-1:0] N1 = SW'(next_fn(KK, 1'b1));
      assign nxt0_tbl[k] = N0;
      assign nxt1_tbl[k] = N1;
   end

   state_e state_q, state_d;

   // Next-state lookup; encodings above S_MATCH fall back to idle.
   always_comb begin
      state_d = S_IDLE;
      if (state_q <= S_MATCH) begin
         state_d = sequence_in ? state_e'(nxt1_tbl[state_q])
                               : state_e'(nxt0_tbl[state_q]);
      end
   end

   // State register with synchronous reset taking priority over data.
   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   assign detector_out = (state_q == S_MATCH);

endmodule

// File: tb/tb_sequence_detector_moore_verilog.sv
// Bench for the serial pattern detector: four parameterisations share one
// stimulus stream; a shift-register history model fills a scoreboard queue.
module tb_sequence_detector_moore_verilog;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic sequence_in = 1'b0;
   logic det_ov, det_no, det_110, det_n1;

   always #5 clock = ~clock;

   sequence_detector_moore_verilog dut_ov (
      .clock(clock), .reset(reset), .sequence_in(sequence_in), .detector_out(det_ov));

   sequence_detector_moore_verilog #(.OVERLAP(1'b0)) dut_no (
      .clock(clock), .reset(reset), .sequence_in(sequence_in), .detector_out(det_no));

   sequence_detector_moore_verilog #(.PATTERN(16'b110), .PATTERN_LEN(3)) dut_110 (
      .clock(clock), .reset(reset), .sequence_in(sequence_in), .detector_out(det_110));

   sequence_detector_moore_verilog #(.PATTERN(16'b1), .PATTERN_LEN(1)) dut_n1 (
      .clock(clock), .reset(reset), .sequence_in(sequence_in), .detector_out(det_n1));

   wire [3:0] out_vec = {det_n1, det_110, det_no, det_ov};

   int checks = 0;
   int errors = 0;

   logic [3:0]  sb [$];
   logic [15:0] hist = '0;
   int          hlen_ov = 0;
   int          hlen_no = 0;

   function automatic logic model_match(input logic [15:0] h, input int hl,
                                        input logic [15:0] pat, input int len);
      logic [15:0] mask;
      mask = (16'h1 << len) - 16'h1;
      return (hl >= len) && ((h & mask) == pat);
   endfunction

   // Drive one bit (or a reset cycle) and push what each DUT must show after
   // the next rising edge; returns #1 after that edge.
   task automatic drive(input logic b, input logic rst);
      logic m_ov, m_no, m_110, m_n1;
      @(negedge clock);
      reset       = rst;
      sequence_in = b;
      m_ov = 0; m_no = 0; m_110 = 0; m_n1 = 0;
      if (rst) begin
         hlen_ov = 0;
         hlen_no = 0;
      end else begin
         hist = {hist[14:0], b};
         if (hlen_ov < 16) hlen_ov++;
         if (hlen_no < 16) hlen_no++;
         m_ov  = model_match(hist, hlen_ov, 16'b1011, 4);
         m_no  = model_match(hist, hlen_no, 16'b1011, 4);
         m_110 = model_match(hist, hlen_ov, 16'b110, 3);
         m_n1  = model_match(hist, hlen_ov, 16'b1, 1);
         if (m_no) hlen_no = 0;
      end
      sb.push_back({m_n1, m_110, m_no, m_ov});
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] exp;
      for (int i = 0; i < 10; i++) begin
         drive(i[0], 1'b1);
         exp = sb.pop_front();
         checks++;
         if (out_vec !== 4'b0000 || exp !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got=%b exp=0000", i, out_vec);
         end
      end
   endtask

   task automatic test_basic_match();
      logic [3:0] exp;
      logic [4:0] bits = 5'b10111;
      drive(1'b0, 1'b1);
      void'(sb.pop_front());
      for (int i = 4; i >= 0; i--) begin
         drive(bits[i], 1'b0);
         exp = sb.pop_front();
         checks++;
         if (out_vec !== exp) begin
            errors++;
            $display("FAIL basic_match bit=%0d got=%b exp=%b", 4 - i, out_vec, exp);
         end
         if (i == 1) begin
            checks++;
            if (det_ov !== 1'b1) begin
               errors++;
               $display("FAIL basic_pulse got=%b exp=1", det_ov);
            end
         end
      end
   endtask

   task automatic test_overlap();
      logic [3:0] exp;
      logic [6:0] bits = 7'b1011011;
      int p_ov = 0, p_no = 0;
      drive(1'b0, 1'b1);
      void'(sb.pop_front());
      for (int i = 6; i >= 0; i--) begin
         drive(bits[i], 1'b0);
         exp = sb.pop_front();
         p_ov += int'(det_ov);
         p_no += int'(det_no);
         checks++;
         if (out_vec !== exp) begin
            errors++;
            $display("FAIL overlap bit=%0d got=%b exp=%b", 7 - i, out_vec, exp);
         end
      end
      checks++;
      if (p_ov != 2 || p_no != 1) begin
         errors++;
         $display("FAIL overlap_count got=%0d/%0d exp=2/1", p_ov, p_no);
      end
   endtask

   task automatic test_near_miss();
      logic [3:0] exp;
      logic [9:0] bits = 10'b10011_11011;
      int p_ov = 0;
      drive(1'b0, 1'b1);
      void'(sb.pop_front());
      for (int i = 9; i >= 0; i--) begin
         if (i == 4) begin
            drive(1'b0, 1'b1);
            void'(sb.pop_front());
         end
         drive(bits[i], 1'b0);
         exp = sb.pop_front();
         p_ov += int'(det_ov);
         checks++;
         if (out_vec !== exp) begin
            errors++;
            $display("FAIL near_miss idx=%0d got=%b exp=%b", 9 - i, out_vec, exp);
         end
      end
      checks++;
      if (p_ov != 1) begin
         errors++;
         $display("FAIL near_miss_count got=%0d exp=1", p_ov);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] exp;
      logic [7:0] bits = 8'b101_x_1011;
      int p_ov = 0;
      drive(1'b0, 1'b1);
      void'(sb.pop_front());
      for (int i = 7; i >= 0; i--) begin
         drive((i == 4) ? 1'b1 : bits[i], i == 4);
         exp = sb.pop_front();
         p_ov += int'(det_ov);
         checks++;
         if (out_vec !== exp) begin
            errors++;
            $display("FAIL reset_mid idx=%0d got=%b exp=%b", 7 - i, out_vec, exp);
         end
         if (i == 1) begin
            checks++;
            if (det_ov !== 1'b0) begin
               errors++;
               $display("FAIL reset_mid_discard got=%b exp=0", det_ov);
            end
         end
      end
      checks++;
      if (p_ov != 1) begin
         errors++;
         $display("FAIL reset_mid_count got=%0d exp=1", p_ov);
      end
   endtask

   task automatic test_param_sweep();
      logic [3:0] exp;
      logic [3:0] bits = 4'b1110;
      int p_110 = 0, p_n1 = 0;
      drive(1'b0, 1'b1);
      void'(sb.pop_front());
      for (int i = 3; i >= 0; i--) begin
         drive(bits[i], 1'b0);
         exp = sb.pop_front();
         p_110 += int'(det_110);
         p_n1  += int'(det_n1);
         checks++;
         if (out_vec !== exp) begin
            errors++;
            $display("FAIL param_sweep bit=%0d got=%b exp=%b", 4 - i, out_vec, exp);
         end
      end
      checks++;
      if (p_110 != 1 || p_n1 != 3) begin
         errors++;
         $display("FAIL param_count got=%0d/%0d exp=1/3", p_110, p_n1);
      end
   endtask

   task automatic test_random();
      logic [3:0] exp;
      logic       b, r;
      drive(1'b0, 1'b1);
      void'(sb.pop_front());
      for (int i = 0; i < 10000; i++) begin
         b = 1'($urandom_range(1));
         r = ($urandom_range(127) == 0);
         drive(b, r);
         exp = sb.pop_front();
         checks++;
         if (out_vec !== exp) begin
            errors++;
            if (errors < 20)
               $display("FAIL random i=%0d got=%b exp=%b", i, out_vec, exp);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_match();
      test_overlap();
      test_near_miss();
      test_reset_mid();
      test_param_sweep();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
